// File: rtl/sm_uart_tx.sv
// rtl/sm_uart_tx.sv - memory-mapped 8N1 UART transmitter (LSB first) with a small transmit FIFO
module sm_uart_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = $clog2(BAUD_DIV);
  localparam logic [TW-1:0]      TIMER_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [FIFO_LOG2:0] DEPTH_CNT  = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT                state, nextState;
  logic [TW-1:0]        timer;
  logic [7:0]           shiftReg, shiftNext;
  logic [2:0]           bitIdx;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wrPtr, rdPtr;
  logic [FIFO_LOG2:0]   count;
  logic [7:0]           ovfCnt;
  logic                 en, ie;
  logic                 txNext;

  logic empty, full, busy, bitDone, pop, push, pushOk, ctrlWr, ovfWr;
  logic unusedBits;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign busy    = (state != IDLE);
  assign bitDone = (timer == '0);
  assign push    = sel && we && (addr == 2'd0);
  assign ctrlWr  = sel && we && (addr == 2'd2);
  assign ovfWr   = sel && we && (addr == 2'd3);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pushOk  = push && (!full || pop);
  assign unusedBits = ^wdata[31:8];

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          nextState = START;
        end
      end
      START: if (bitDone) nextState = DATA;
      DATA:  if (bitDone && bitIdx == 3'd7) nextState = STOP;
      STOP: begin
        if (bitDone) begin
          if (en && !empty) begin
            pop       = 1'b1;
            nextState = START;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state and shift value about to be entered.
  always_comb begin
    shiftNext = shiftReg;
    txNext    = 1'b1;
    if (pop) shiftNext = mem[rdPtr];
    else if (state == DATA && bitDone) shiftNext = {1'b0, shiftReg[7:1]};
    case (nextState)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      irq      <= 1'b0;
      timer    <= '0;
      shiftReg <= '0;
      bitIdx   <= '0;
    end else begin
      tx       <= txNext;
      irq      <= ie & empty & ~busy;
      shiftReg <= shiftNext;
      if (nextState == IDLE)   timer <= '0;
      else if (pop || bitDone) timer <= TIMER_LOAD;
      else                     timer <= timer - 1'b1;
      if (state == START)                bitIdx <= '0;
      else if (state == DATA && bitDone) bitIdx <= bitIdx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      ovfCnt <= '0;
      en     <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovfWr) ovfCnt <= '0;
      else if (push && full && !pop && ovfCnt != 8'hFF) ovfCnt <= ovfCnt + 1'b1;
      if (ctrlWr) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        2'd1: begin
          rdata[0] = empty;
          rdata[1] = full;
          rdata[2] = busy;
          rdata[8 +: FIFO_LOG2 + 1] = count;
        end
        2'd2:    rdata[1:0] = {ie, en};
        2'd3:    rdata[7:0] = ovfCnt;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_uart_tx.sv
// tb/tb_sm_uart_tx.sv - directed self-checking bench for sm_uart_tx (BAUD_DIV=4, FIFO_LOG2=2)
module tb_sm_uart_tx;

  localparam int BD = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int          nCmp = 0;
  int          nErr = 0;
  logic [31:0] rd;
  logic [7:0]  ovfBytes [5];

  sm_uart_tx #(.BAUD_DIV(BD), .FIFO_LOG2(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    d   = rdata;
    sel = 1'b0;
  endtask

  // Expected line level c cycles into a frame: 4 start, 32 data (LSB first), 4 stop.
  function automatic logic expBit(input logic [7:0] b, input int c);
    if (c < BD) return 1'b0;
    if (c < 9 * BD) return b[(c - BD) / BD];
    return 1'b1;
  endfunction

  task automatic checkBits(input logic [7:0] b, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      tick();
      check($sformatf("tx_%02h_c%0d", b, c), 32'(tx), 32'(expBit(b, c)));
    end
  endtask

  initial begin
    rst   = 1'b1;
    sel   = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    ovfBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    busRead(2'd1, rd); check("rst_status", rd, 32'h1);
    busRead(2'd2, rd); check("rst_ctrl", rd, 32'h0);
    busRead(2'd3, rd); check("rst_ovf", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single frame 0xA5
    busWrite(2'd2, 32'h1);
    busRead(2'd2, rd); check("ctrl_en", rd, 32'h1);
    busWrite(2'd0, 32'hA5);
    check("tx_before_pop", 32'(tx), 32'd1);
    busRead(2'd0, rd); check("data_reads0", rd, 32'h0);
    checkBits(8'hA5, 0, 10 * BD - 1);
    tick();
    busRead(2'd1, rd); check("a5_done_status", rd, 32'h1);
    check("a5_done_irq", 32'(irq), 32'd0);

    // overflow with transmitter disabled
    busWrite(2'd2, 32'h0);
    for (int i = 0; i < 5; i++) busWrite(2'd0, 32'(ovfBytes[i]));
    busRead(2'd1, rd); check("full_status", rd, 32'h402);
    busRead(2'd3, rd); check("ovf_1", rd, 32'h1);
    check("full_tx_idle", 32'(tx), 32'd1);
    busWrite(2'd0, 32'hEE);
    busRead(2'd3, rd); check("ovf_2", rd, 32'h2);
    busWrite(2'd3, 32'h0);
    busRead(2'd3, rd); check("ovf_clear", rd, 32'h0);
    busWrite(2'd0, 32'hEF);
    busRead(2'd3, rd); check("ovf_after_clear", rd, 32'h1);

    // drain four bytes back-to-back in push order
    busWrite(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) checkBits(ovfBytes[i], 0, 10 * BD - 1);
    tick();
    busRead(2'd1, rd); check("drain_status", rd, 32'h1);

    // en cleared mid-frame
    busWrite(2'd2, 32'h0);
    busWrite(2'd0, 32'h66);
    busWrite(2'd0, 32'h77);
    busWrite(2'd0, 32'h88);
    busWrite(2'd2, 32'h1);
    checkBits(8'h66, 0, 10);
    busWrite(2'd2, 32'h0);
    checkBits(8'h66, 12, 10 * BD - 1);
    tick();
    busRead(2'd1, rd); check("held_status", rd, 32'h200);
    repeat (8) tick();
    check("held_tx", 32'(tx), 32'd1);
    busRead(2'd1, rd); check("held_status2", rd, 32'h200);

    // interrupt on drain, cleared by a push
    busWrite(2'd2, 32'h3);
    checkBits(8'h77, 0, 10 * BD - 1);
    checkBits(8'h88, 0, 10 * BD - 1);
    check("irq_in_stop", 32'(irq), 32'd0);
    tick();
    busRead(2'd1, rd); check("irq_busy_fell", rd, 32'h1);
    check("irq_delay", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    busWrite(2'd0, 32'h99);
    check("irq_push_edge", 32'(irq), 32'd1);
    tick();
    check("irq_after_push", 32'(irq), 32'd0);
    check("tx_99_start", 32'(tx), 32'd0);
    checkBits(8'h99, 1, 24);

    // asynchronous reset during DATA (line is low here)
    rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    busRead(2'd1, rd); check("post_rst_status", rd, 32'h1);
    busRead(2'd3, rd); check("post_rst_ovf", rd, 32'h0);
    busRead(2'd2, rd); check("post_rst_ctrl", rd, 32'h0);
    check("post_rst_irq", 32'(irq), 32'd0);
    tick();
    check("post_rst_tx", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
